fp_add_operand_preparer: RTL and testbench

Front stage of the single-precision adder's operand preparation. It accepts two IEEE-754 binary32 operands and decodes them. It orders them by magnitude, then emits per-operand 26-bit two's-complement significands, a sign bit for each, the exponent difference and special-case flags. Its outputs feed the alignment shifter directly: the small operand's significand, sign and shift go to the shifter; the big operand passes at shift 0. It is a 2-stage pipeline with a valid/ready handshake.

---
 rtl/fp_add_operand_preparer.sv | 218 +++++++++++++++++++++
 tb/tb_fp_add_operand_preparer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fp_add_operand_preparer.sv
// Operand preparation front stage for the binary32 adder: decodes, orders by magnitude,
// and forms two's-complement significands plus special-case flags over a 2-stage pipe.
module fp_add_operand_preparer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [25:0] big_mant,
  output logic        big_sig,
  output logic [25:0] small_mant,
  output logic        small_sig,
  output logic [7:0]  shift,
  output logic [7:0]  exp_max,
  output logic        swapped,
  output logic        nan_flag,
  output logic        inf_flag,
  output logic        inf_sign
);

  function automatic logic [7:0] eff_exp(input logic [31:0] x);
    return (x[30:23] == 8'h00) ? 8'h01 : x[30:23];
  endfunction

  function automatic logic [23:0] signif(input logic [31:0] x);
    return {(x[30:23] != 8'h00), x[22:0]};
  endfunction

  function automatic logic [25:0] twos(input logic s, input logic [23:0] m);
    logic [25:0] mag;
    mag = {2'b00, m};
    return s ? (~mag + 26'd1) : mag;
  endfunction

  logic        adv_s;

  logic        s1_valid_q,   s1_valid_d;
  logic        s1_big_s_q,   s1_big_s_d;
  logic [23:0] s1_big_m_q,   s1_big_m_d;
  logic        s1_small_s_q, s1_small_s_d;
  logic [23:0] s1_small_m_q, s1_small_m_d;
  logic [7:0]  s1_shift_q,   s1_shift_d;
  logic [7:0]  s1_exp_q,     s1_exp_d;
  logic        s1_swap_q,    s1_swap_d;
  logic [5:0]  s1_spec_q,    s1_spec_d;   // {a_nan, b_nan, a_inf, b_inf, a_s, b_s}

  logic        out_valid_q,  out_valid_d;
  logic [25:0] big_mant_q,   big_mant_d;
  logic        big_sig_q,    big_sig_d;
  logic [25:0] small_mant_q, small_mant_d;
  logic        small_sig_q,  small_sig_d;
  logic [7:0]  shift_q,      shift_d;
  logic [7:0]  exp_max_q,    exp_max_d;
  logic        swapped_q,    swapped_d;
  logic        nan_q,        nan_d;
  logic        inf_q,        inf_d;
  logic        inf_sign_q,   inf_sign_d;

  assign adv_s    = !(out_valid_q && !out_ready);
  assign in_ready = adv_s;

  // Stage 1: decode, magnitude compare, swap and exponent difference
  always_comb begin
    logic [7:0]  a_ee, b_ee;
    logic [23:0] a_m,  b_m;
    logic        a_big;
    a_ee  = eff_exp(a);
    b_ee  = eff_exp(b);
    a_m   = signif(a);
    b_m   = signif(b);
    a_big = ({a_ee, a_m} >= {b_ee, b_m});

    s1_valid_d   = s1_valid_q;
    s1_big_s_d   = s1_big_s_q;
    s1_big_m_d   = s1_big_m_q;
    s1_small_s_d = s1_small_s_q;
    s1_small_m_d = s1_small_m_q;
    s1_shift_d   = s1_shift_q;
    s1_exp_d     = s1_exp_q;
    s1_swap_d    = s1_swap_q;
    s1_spec_d    = s1_spec_q;

    if (adv_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        if (a_big) begin
          s1_big_s_d   = a[31];
          s1_big_m_d   = a_m;
          s1_small_s_d = b[31];
          s1_small_m_d = b_m;
          s1_shift_d   = a_ee - b_ee;
          s1_exp_d     = a_ee;
          s1_swap_d    = 1'b0;
        end else begin
          s1_big_s_d   = b[31];
          s1_big_m_d   = b_m;
          s1_small_s_d = a[31];
          s1_small_m_d = a_m;
          s1_shift_d   = b_ee - a_ee;
          s1_exp_d     = b_ee;
          s1_swap_d    = 1'b1;
        end
        s1_spec_d = {(a[30:23] == 8'hFF) && (a[22:0] != 23'd0),
                     (b[30:23] == 8'hFF) && (b[22:0] != 23'd0),
                     (a[30:23] == 8'hFF) && (a[22:0] == 23'd0),
                     (b[30:23] == 8'hFF) && (b[22:0] == 23'd0),
                     a[31], b[31]};
      end else begin
        s1_spec_d = s1_spec_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2: significand negation and special-case flag resolution
  always_comb begin
    logic a_nan, b_nan, a_inf, b_inf, a_s, b_s, nan_v;
    {a_nan, b_nan, a_inf, b_inf, a_s, b_s} = s1_spec_q;
    nan_v = a_nan || b_nan || (a_inf && b_inf && (a_s != b_s));

    out_valid_d  = out_valid_q;
    big_mant_d   = big_mant_q;
    big_sig_d    = big_sig_q;
    small_mant_d = small_mant_q;
    small_sig_d  = small_sig_q;
    shift_d      = shift_q;
    exp_max_d    = exp_max_q;
    swapped_d    = swapped_q;
    nan_d        = nan_q;
    inf_d        = inf_q;
    inf_sign_d   = inf_sign_q;

    if (adv_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        big_mant_d   = twos(s1_big_s_q, s1_big_m_q);
        big_sig_d    = s1_big_s_q;
        small_mant_d = twos(s1_small_s_q, s1_small_m_q);
        small_sig_d  = s1_small_s_q;
        shift_d      = s1_shift_q;
        exp_max_d    = s1_exp_q;
        swapped_d    = s1_swap_q;
        nan_d        = nan_v;
        inf_d        = !nan_v && (a_inf || b_inf);
        // sign only meaningful when the result really is an infinity
        inf_sign_d   = (!nan_v && (a_inf || b_inf)) ? (a_inf ? a_s : b_s) : 1'b0;
      end else begin
        nan_d = nan_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_big_s_q   <= 1'b0;
      s1_big_m_q   <= 24'd0;
      s1_small_s_q <= 1'b0;
      s1_small_m_q <= 24'd0;
      s1_shift_q   <= 8'd0;
      s1_exp_q     <= 8'd0;
      s1_swap_q    <= 1'b0;
      s1_spec_q    <= 6'd0;
      out_valid_q  <= 1'b0;
      big_mant_q   <= 26'd0;
      big_sig_q    <= 1'b0;
      small_mant_q <= 26'd0;
      small_sig_q  <= 1'b0;
      shift_q      <= 8'd0;
      exp_max_q    <= 8'd0;
      swapped_q    <= 1'b0;
      nan_q        <= 1'b0;
      inf_q        <= 1'b0;
      inf_sign_q   <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_big_s_q   <= s1_big_s_d;
      s1_big_m_q   <= s1_big_m_d;
      s1_small_s_q <= s1_small_s_d;
      s1_small_m_q <= s1_small_m_d;
      s1_shift_q   <= s1_shift_d;
      s1_exp_q     <= s1_exp_d;
      s1_swap_q    <= s1_swap_d;
      s1_spec_q    <= s1_spec_d;
      out_valid_q  <= out_valid_d;
      big_mant_q   <= big_mant_d;
      big_sig_q    <= big_sig_d;
      small_mant_q <= small_mant_d;
      small_sig_q  <= small_sig_d;
      shift_q      <= shift_d;
      exp_max_q    <= exp_max_d;
      swapped_q    <= swapped_d;
      nan_q        <= nan_d;
      inf_q        <= inf_d;
      inf_sign_q   <= inf_sign_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign big_mant   = big_mant_q;
  assign big_sig    = big_sig_q;
  assign small_mant = small_mant_q;
  assign small_sig  = small_sig_q;
  assign shift      = shift_q;
  assign exp_max    = exp_max_q;
  assign swapped    = swapped_q;
  assign nan_flag   = nan_q;
  assign inf_flag   = inf_q;
  assign inf_sign   = inf_sign_q;

endmodule

// File: tb/tb_fp_add_operand_preparer.sv
// Directed, table-driven bench for fp_add_operand_preparer: vector table, backpressure
// stream and mid-stream reset sequences.
module tb_fp_add_operand_preparer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] big_mant, small_mant;
  logic        big_sig, small_sig;
  logic [7:0]  shift, exp_max;
  logic        swapped, nan_flag, inf_flag, inf_sign;

  fp_add_operand_preparer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .big_mant(big_mant), .big_sig(big_sig),
    .small_mant(small_mant), .small_sig(small_sig), .shift(shift), .exp_max(exp_max),
    .swapped(swapped), .nan_flag(nan_flag), .inf_flag(inf_flag), .inf_sign(inf_sign)
  );

  always #5 clk = ~clk;

  logic [73:0] got;
  assign got = {big_mant, big_sig, small_mant, small_sig, shift, exp_max,
                swapped, nan_flag, inf_flag, inf_sign};

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [73:0] exp;
  } vec_t;

  vec_t vecs[9];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [73:0] mk(input logic [25:0] bm, input logic bs,
                                     input logic [25:0] sm, input logic ss,
                                     input logic [7:0] sh, input logic [7:0] em,
                                     input logic sw, input logic nan, input logic inf,
                                     input logic isg);
    return {bm, bs, sm, ss, sh, em, sw, nan, inf, isg};
  endfunction

  task automatic chk(input string name, input logic [73:0] act, input logic [73:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  initial begin
    int sent, recv, stall_left;
    bit stall_started, post_stall, have_snap;
    logic [73:0] snap;

    vecs[0] = '{32'h3F800000, 32'h40000000, mk(26'h0800000,1'b0,26'h0800000,1'b0,8'h01,8'h80,1'b1,1'b0,1'b0,1'b0)};
    vecs[1] = '{32'hBF800000, 32'h3F000000, mk(26'h3800000,1'b1,26'h0800000,1'b0,8'h01,8'h7F,1'b0,1'b0,1'b0,1'b0)};
    vecs[2] = '{32'h00000001, 32'h00800000, mk(26'h0800000,1'b0,26'h0000001,1'b0,8'h00,8'h01,1'b1,1'b0,1'b0,1'b0)};
    vecs[3] = '{32'h80000000, 32'h00000000, mk(26'h0000000,1'b1,26'h0000000,1'b0,8'h00,8'h01,1'b0,1'b0,1'b0,1'b0)};
    vecs[4] = '{32'h7F800000, 32'hFF800000, mk(26'h0800000,1'b0,26'h3800000,1'b1,8'h00,8'hFF,1'b0,1'b1,1'b0,1'b0)};
    vecs[5] = '{32'h7FC00000, 32'h3F800000, mk(26'h0C00000,1'b0,26'h0800000,1'b0,8'h80,8'hFF,1'b0,1'b1,1'b0,1'b0)};
    vecs[6] = '{32'h3F800000, 32'hFF800000, mk(26'h3800000,1'b1,26'h0800000,1'b0,8'h80,8'hFF,1'b1,1'b0,1'b1,1'b1)};
    vecs[7] = '{32'hC0400000, 32'hC0400000, mk(26'h3400000,1'b1,26'h3400000,1'b1,8'h00,8'h80,1'b0,1'b0,1'b0,1'b0)};
    vecs[8] = '{32'h7F7FFFFF, 32'h00000000, mk(26'h0FFFFFF,1'b0,26'h0000000,1'b0,8'hFD,8'hFE,1'b0,1'b0,1'b0,1'b0)};

    rst = 1'b1; in_valid = 1'b0; a = 32'd0; b = 32'd0; out_ready = 1'b1;
    #12;
    chk("reset_out_valid", 74'(out_valid), 74'd0);
    chk("reset_outputs", got, 74'd0);
    chk("reset_in_ready", 74'(in_ready), 74'd1);
    @(negedge clk) rst = 1'b0;

    // Single pairs through an empty pipe: latency and field values
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), 74'(in_ready), 74'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_early_valid", i), 74'(out_valid), 74'd0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 74'(out_valid), 74'd1);
      chk($sformatf("vec%0d_fields", i), got, vecs[i].exp);
    end

    // Backpressure: 8 back-to-back pairs, 3-cycle stall at first out_valid
    sent = 0; recv = 0; stall_left = 0;
    stall_started = 1'b0; post_stall = 1'b0; have_snap = 1'b0; snap = 74'd0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      @(posedge clk); #1;
      if (out_valid && !stall_started) begin
        stall_started = 1'b1;
        stall_left = 3;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      in_valid = (sent < 8);
      if (sent < 8) begin
        a = vecs[sent].a; b = vecs[sent].b;
      end
      @(negedge clk);
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", 74'(in_ready), 74'd0);
        if (have_snap) chk("stall_stable", got, snap);
        snap = got;
        have_snap = 1'b1;
      end
      if (post_stall && recv < 8) chk("throughput_valid", 74'(out_valid), 74'd1);
      if (out_valid && out_ready) begin
        chk($sformatf("stream_result%0d", recv), got, vecs[recv].exp);
        recv++;
        post_stall = stall_started;
      end
      if (in_valid && in_ready) sent++;
    end
    chk("stream_count", 74'(recv), 74'd8);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("stream_no_dup", 74'(out_valid), 74'd0);

    // Asynchronous reset with two pairs in flight
    @(posedge clk); #1;
    in_valid = 1'b1; a = vecs[0].a; b = vecs[0].b;
    @(posedge clk); #1;
    a = vecs[1].a; b = vecs[1].b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    chk("pre_reset_valid", 74'(out_valid), 74'd1);
    rst = 1'b1;
    #1;
    chk("async_reset_valid", 74'(out_valid), 74'd0);
    chk("async_reset_outputs", got, 74'd0);
    chk("async_reset_in_ready", 74'(in_ready), 74'd1);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_reset_stale%0d", k), 74'(out_valid), 74'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b1; a = vecs[6].a; b = vecs[6].b;
    @(negedge clk);
    chk("post_reset_in_ready", 74'(in_ready), 74'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_reset_valid", 74'(out_valid), 74'd1);
    chk("post_reset_fields", got, vecs[6].exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
